sa_col_collect: RTL and testbench
=================================

# sa_col_collect

Downstream consumer of the systolic array's rotating one-hot column select. Each cycle it captures one column's result word into the slot named by the one-hot select. Once every column slot has been written, it presents the assembled row as one wide word on a valid/ready interface. While a completed row waits for the consumer, it asserts a stall so the upstream enable can be dropped.

## Interface
- `COL`, default 3, number of array columns and slots (≥1)
- `DATA_W`, default 16, width of one column result word
- `i_clk`  input  1  clock; all logic on rising edge
- `i_rst_n`  input  1  synchronous active-low reset
- `i_col_sel`  input  COL  one-hot column select from the column shift register
- `i_col_data`  input  DATA_W  result word for the selected column
- `i_col_valid`  input  1  `i_col_data` and `i_col_sel` are meaningful this cycle
- `o_row_data`  output  COL*DATA_W  assembled row; slot k at bits [k*DATA_W +: DATA_W]
- `o_row_valid`  output  1  row complete and held
- `i_row_ready`  input  1  consumer accepts the row when high together with `o_row_valid`
- `o_stall`  output  1  high in HOLD; upstream must deassert its column enable
- `o_err_sel`  output  1  sticky; a valid write had a non-one-hot `i_col_sel`
- `o_overflow`  output  1  sticky; a valid write arrived in HOLD without a handshake

## Operation
- Two states, encoded in the package:
  - **FILL**: slots are being written.
  - **HOLD**: row is complete and waiting for the consumer.
- Internal COL-bit `filled` mask plus COL×DATA_W slot registers.
- **FILL, `i_col_valid`=1, `i_col_sel` one-hot:**
  - write `i_col_data` into the selected slot;
  - set that slot's `filled` bit;
  - if the slot was already filled, overwrite it (last write wins, no flag).
- **FILL, `i_col_valid`=1, `i_col_sel` zero or multi-hot:**
  - no write;
  - set `o_err_sel`.
- **FILL → HOLD:** when `filled` OR the current write's bit equals all ones.
- **HOLD, handshake** (`o_row_valid` & `i_row_ready`):
  - clear `filled`;
  - go to FILL;
  - a valid one-hot write in the same cycle is accepted into the new row and sets only its own bit;
  - for COL=1, that write completes the new row and the state stays HOLD.
- **HOLD, no handshake, `i_col_valid`=1:**
  - write is dropped;
  - set `o_overflow`;
  - held data is unchanged.
- **Slot data:** not cleared on handshake. New writes overwrite it; unwritten slots are never exposed because the row is only valid when every slot is filled.
- **Sticky flags:** cleared only by reset.
- **`i_col_valid`=0:** no state change, except the HOLD handshake.

## Timing
- **Reset values:** state FILL, `filled`=0, all slots 0, `o_row_data`=0, `o_row_valid`=0, `o_stall`=0, `o_err_sel`=0, `o_overflow`=0.
- **Reset mid-row or mid-HOLD:** the partial or held row is discarded and everything returns to the reset values on the next edge.
- **Latency:** the write that completes the row at edge N gives `o_row_valid`=1 and `o_stall`=1 from edge N onward (first visible in cycle N+1).
- **Output register:** `o_row_data` is read directly from the slot registers and is stable while `o_row_valid` is high.
- **Handshake at edge M:** `o_row_valid` and `o_stall` are low after M, unless COL=1 with a same-cycle write.
- **Throughput:** with a continuously rotating select and `i_row_ready` tied high, one row every COL cycles with no bubbles.
- **`o_stall` timing:** registered and equal to (state==HOLD); it does not depend combinationally on `i_row_ready`.
- **`o_err_sel` / `o_overflow`:** set at the edge after the offending cycle.

## Structure
- **Package `sa_pkg`:**
  - `collect_state_t` enum {FILL, HOLD};
  - function `is_onehot(vec)`.
- **Sub-module `sa_onehot_check`:**
  - combinational, parameter COL;
  - outputs `o_onehot` for `i_col_sel`;
  - reused by other array stages.
- **Top:** state register, `filled` mask, slot array and flags, all in one clocked process.

## Test plan
- **Normal fill:** COL=3, DATA_W=16, ready=1; sel 001/010/100 with data 0x0011/0x0022/0x0033 → `o_row_valid` one cycle after the third write, `o_row_data`=0x0033_0022_0011, then FILL.
- **Back-pressure:** ready=0 after completion; write sel=001 data 0xDEAD → `o_stall`=1, `o_overflow`=1, `o_row_data` unchanged. Raise ready → handshake, `o_stall`=0 next cycle.
- **Handshake with same-cycle write:** HOLD with ready=1 and a write sel=010 data 0x5555 → row consumed, new `filled`=010, slot1=0x5555, row incomplete.
- **Bad select:** valid with sel=000, then sel=011 → no slot written, `filled` unchanged, `o_err_sel`=1 sticky.
- **Duplicate slot:** sel 001 with 0x1, then 001 with 0x2, then 010 and 100 → row slot0=0x2.
- **Reset mid-row:** two slots filled, `i_rst_n`=0 for one cycle → all outputs 0; a following full fill produces a correct row. Repeat with COL=1: each valid write completes a row.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic-array collection stages.
package sa_pkg;

  // Widest column select any stage hands to is_onehot().
  localparam int unsigned MaxCol = 64;

  typedef enum logic {FILL, HOLD} collect_state_t;

  function automatic logic is_onehot(input logic [MaxCol-1:0] vec);
    return (vec != '0) && ((vec & (vec - MaxCol'(1))) == '0);
  endfunction

endpackage

// File: rtl/sa_onehot_check.sv
// Combinational one-hot detector for a COL-bit column select.
module sa_onehot_check
  import sa_pkg::*;
#(
  parameter int unsigned COL = 3
) (
  input  logic [COL-1:0] i_col_sel,
  output logic           o_onehot
);

  assign o_onehot = is_onehot(MaxCol'(i_col_sel));

endmodule

// File: rtl/sa_col_collect.sv
// Gathers one result word per column into a row, then holds it for a valid/ready consumer.
module sa_col_collect
  import sa_pkg::*;
#(
  parameter int unsigned COL    = 3,
  parameter int unsigned DATA_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [COL-1:0]        i_col_sel,
  input  logic [DATA_W-1:0]     i_col_data,
  input  logic                  i_col_valid,
  output logic [COL*DATA_W-1:0] o_row_data,
  output logic                  o_row_valid,
  input  logic                  i_row_ready,
  output logic                  o_stall,
  output logic                  o_err_sel,
  output logic                  o_overflow
);

  collect_state_t        state_q, state_d;
  logic [COL-1:0]        filled_q, filled_d;
  logic [COL*DATA_W-1:0] row_q, row_d;
  logic                  err_q, err_d;
  logic                  ovf_q, ovf_d;

  logic sel_ok;
  logic in_fill, handshake, open_row, accept;
  logic [COL-1:0] base_mask;

  sa_onehot_check #(
    .COL (COL)
  ) u_onehot (
    .i_col_sel (i_col_sel),
    .o_onehot  (sel_ok)
  );

  always_comb begin
    in_fill   = (state_q == FILL);
    handshake = (state_q == HOLD) && i_row_ready;
    // A handshake cycle behaves like FILL starting from an empty mask.
    open_row  = in_fill || handshake;
    accept    = open_row && i_col_valid && sel_ok;
    base_mask = handshake ? '0 : filled_q;

    state_d  = state_q;
    filled_d = filled_q;
    row_d    = row_q;
    err_d    = err_q || (open_row && i_col_valid && !sel_ok);
    ovf_d    = ovf_q || ((state_q == HOLD) && !i_row_ready && i_col_valid);

    if (open_row) begin
      filled_d = base_mask;
      state_d  = FILL;
    end
    if (accept) begin
      filled_d = base_mask | i_col_sel;
      for (int unsigned k = 0; k < COL; k++) begin
        if (i_col_sel[k]) row_d[k*DATA_W +: DATA_W] = i_col_data;
      end
      if (&filled_d) state_d = HOLD;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= FILL;
      filled_q <= '0;
      row_q    <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      filled_q <= filled_d;
      row_q    <= row_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o_row_data  = row_q;
  assign o_row_valid = (state_q == HOLD);
  assign o_stall     = (state_q == HOLD);
  assign o_err_sel   = err_q;
  assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_sa_col_collect.sv
// Directed scoreboard bench for sa_col_collect with a COL=3 and a COL=1 instance.
module tb_sa_col_collect;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  sel3;
  logic [15:0] data3;
  logic        valid3, ready3;
  logic [47:0] row3;
  logic        rv3, stall3, err3, ovf3;

  logic [0:0]  sel1;
  logic [15:0] data1;
  logic        valid1, ready1;
  logic [15:0] row1;
  logic        rv1, stall1, err1, ovf1;

  int vectors = 0;
  int miscompares = 0;
  logic [47:0] sb[$];

  always #5 clk = ~clk;

  sa_col_collect #(.COL(3), .DATA_W(16)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_col_sel(sel3), .i_col_data(data3),
    .i_col_valid(valid3), .o_row_data(row3), .o_row_valid(rv3), .i_row_ready(ready3),
    .o_stall(stall3), .o_err_sel(err3), .o_overflow(ovf3)
  );

  sa_col_collect #(.COL(1), .DATA_W(16)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_col_sel(sel1), .i_col_data(data1),
    .i_col_valid(valid1), .o_row_data(row1), .o_row_valid(rv1), .i_row_ready(ready1),
    .o_stall(stall1), .o_err_sel(err1), .o_overflow(ovf1)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_row(input string tag);
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: observed %h expected <scoreboard empty>", tag, row3);
    end else begin
      chk(tag, row3, sb.pop_front());
    end
  endtask

  task automatic wr3(input logic [2:0] s, input logic [15:0] d);
    sel3 = s; data3 = d; valid3 = 1'b1;
    cyc();
    valid3 = 1'b0;
  endtask

  task automatic wr1(input logic [15:0] d);
    sel1 = 1'b1; data1 = d; valid1 = 1'b1;
    cyc();
    valid1 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sel3 = '0; data3 = '0; valid3 = 1'b0; ready3 = 1'b1;
    sel1 = '0; data1 = '0; valid1 = 1'b0; ready1 = 1'b0;
    cyc(); cyc();
    chk("rst_row", row3, 48'h0);
    chk("rst_valid", rv3, 1'b0);
    chk("rst_stall", stall3, 1'b0);
    chk("rst_err", err3, 1'b0);
    chk("rst_ovf", ovf3, 1'b0);
    rst_n = 1'b1;

    // Normal fill
    wr3(3'b001, 16'h0011);
    chk("fill_v1", rv3, 1'b0);
    wr3(3'b010, 16'h0022);
    chk("fill_v2", rv3, 1'b0);
    sb.push_back(48'h0033_0022_0011);
    wr3(3'b100, 16'h0033);
    chk("fill_valid", rv3, 1'b1);
    chk("fill_stall", stall3, 1'b1);
    chk_row("fill_row");
    cyc();
    chk("fill_consumed", rv3, 1'b0);

    // Back-pressure
    ready3 = 1'b0;
    wr3(3'b001, 16'h0101);
    wr3(3'b010, 16'h0202);
    sb.push_back(48'h0303_0202_0101);
    wr3(3'b100, 16'h0303);
    chk("bp_valid", rv3, 1'b1);
    wr3(3'b001, 16'hDEAD);
    chk("bp_stall", stall3, 1'b1);
    chk("bp_ovf", ovf3, 1'b1);
    chk("bp_held", row3, sb[0]);
    ready3 = 1'b1;
    chk_row("bp_row");
    cyc();
    chk("bp_stall_low", stall3, 1'b0);
    chk("bp_valid_low", rv3, 1'b0);

    // Handshake with same-cycle write
    ready3 = 1'b0;
    wr3(3'b001, 16'h0001);
    wr3(3'b010, 16'h0002);
    wr3(3'b100, 16'h0003);
    chk("hs_hold", rv3, 1'b1);
    ready3 = 1'b1;
    wr3(3'b010, 16'h5555);
    chk("hs_incomplete", rv3, 1'b0);
    wr3(3'b001, 16'hAAAA);
    chk("hs_still_incomplete", rv3, 1'b0);
    sb.push_back(48'hBBBB_5555_AAAA);
    wr3(3'b100, 16'hBBBB);
    chk("hs_valid", rv3, 1'b1);
    chk_row("hs_row");

    // Throughput: rotating select, ready high, no bubbles
    wr3(3'b001, 16'h0A01);
    chk("tp_hs", rv3, 1'b0);
    wr3(3'b010, 16'h0A02);
    sb.push_back(48'h0A03_0A02_0A01);
    wr3(3'b100, 16'h0A03);
    chk("tp_valid1", rv3, 1'b1);
    chk_row("tp_row1");
    wr3(3'b001, 16'h0B01);
    wr3(3'b010, 16'h0B02);
    sb.push_back(48'h0B03_0B02_0B01);
    wr3(3'b100, 16'h0B03);
    chk("tp_valid2", rv3, 1'b1);
    chk_row("tp_row2");
    cyc();

    // Bad select
    wr3(3'b000, 16'hFFFF);
    chk("bad_err", err3, 1'b1);
    wr3(3'b011, 16'hFFFF);
    chk("bad_err_sticky", err3, 1'b1);
    chk("bad_no_row", rv3, 1'b0);
    wr3(3'b001, 16'h0C01);
    wr3(3'b010, 16'h0C02);
    chk("bad_filled_unchanged", rv3, 1'b0);
    sb.push_back(48'h0C03_0C02_0C01);
    wr3(3'b100, 16'h0C03);
    chk_row("bad_row");
    cyc();

    // Duplicate slot: last write wins
    wr3(3'b001, 16'h0001);
    wr3(3'b001, 16'h0002);
    chk("dup_no_row", rv3, 1'b0);
    wr3(3'b010, 16'h0007);
    sb.push_back(48'h0008_0007_0002);
    wr3(3'b100, 16'h0008);
    chk("dup_valid", rv3, 1'b1);
    chk_row("dup_row");
    cyc();

    // COL=1: every valid write completes a row
    wr1(16'h1234);
    chk("c1_valid", rv1, 1'b1);
    chk("c1_row", row1, 16'h1234);
    ready1 = 1'b1;
    wr1(16'h5678);
    chk("c1_hs_write_valid", rv1, 1'b1);
    chk("c1_hs_write_row", row1, 16'h5678);
    ready1 = 1'b0;
    wr1(16'h9999);
    chk("c1_ovf", ovf1, 1'b1);
    chk("c1_row_held", row1, 16'h5678);

    // Reset mid-row
    wr3(3'b001, 16'h0D01);
    wr3(3'b010, 16'h0D02);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("mid_rst_row", row3, 48'h0);
    chk("mid_rst_valid", rv3, 1'b0);
    chk("mid_rst_err", err3, 1'b0);
    chk("mid_rst_ovf", ovf3, 1'b0);
    chk("mid_rst_c1_valid", rv1, 1'b0);
    chk("mid_rst_c1_ovf", ovf1, 1'b0);
    wr3(3'b100, 16'h0E03);
    chk("post_rst_partial", rv3, 1'b0);
    wr3(3'b001, 16'h0E01);
    sb.push_back(48'h0E03_0E02_0E01);
    wr3(3'b010, 16'h0E02);
    chk("post_rst_valid", rv3, 1'b1);
    chk_row("post_rst_row");
    wr1(16'h4321);
    chk("post_rst_c1_row", row1, 16'h4321);
    chk("post_rst_c1_valid", rv1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
